// File: rtl/ball_serve_ctrl.sv
// Pong ball controller: serve handshake with the direction LFSR, launch delay,
// per-frame motion with wall bounces, paddle reflection and score pulses.
module ball_serve_ctrl #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X0          = 80,
  parameter int Y0          = 60,
  parameter int SERVE_DELAY = 60
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       serve_req,
  input  logic       frame_tick,
  input  logic       dir_valid,
  input  logic [2:0] dir_code,
  input  logic       hit_left,
  input  logic       hit_right,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y,
  output logic       ball_active,
  output logic       serve_busy,
  output logic       score_left,
  output logic       score_right
);

  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic signed [9:0] X_MAX  = 10'(SCREEN_W - 1);
  localparam logic signed [9:0] Y_MAX  = 10'(SCREEN_H - 1);
  localparam logic signed [9:0] Y_MAX2 = 10'(2 * (SCREEN_H - 1));

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_DIR = 3'd1,
    DELAY    = 3'd2,
    PLAY     = 3'd3,
    SCORED   = 3'd4
  } state_t;

  state_t             state_r;
  logic signed [2:0]  dx_r;
  logic signed [2:0]  dy_r;
  logic [CNT_W-1:0]   cnt_r;

  logic signed [2:0]  dir_dx_s;
  logic signed [2:0]  dir_dy_s;
  logic signed [9:0]  xe_s;
  logic signed [9:0]  ye_s;
  logic signed [9:0]  nx_s;
  logic signed [9:0]  ny_s;
  logic [6:0]         vy_s;
  logic signed [2:0]  vdy_s;
  logic [7:0]         hx_s;
  logic signed [2:0]  hdx_s;
  logic               exit_left_s;
  logic               exit_right_s;

  // Direction decode from the LFSR code
  always_comb begin
    dir_dx_s = dir_code[2] ? 3'sd2 : -3'sd2;
    case (dir_code[1:0])
      2'b00:   dir_dy_s = -3'sd2;
      2'b01:   dir_dy_s = -3'sd1;
      2'b10:   dir_dy_s = 3'sd1;
      2'b11:   dir_dy_s = 3'sd2;
      default: dir_dy_s = 3'sd1;
    endcase
  end

  // Candidate next position: wall reflection, then paddle/edge priority on x
  always_comb begin
    xe_s = signed'({2'b00, ball_x});
    ye_s = signed'({3'b000, ball_y});
    nx_s = xe_s + signed'({{7{dx_r[2]}}, dx_r});
    ny_s = ye_s + signed'({{7{dy_r[2]}}, dy_r});

    if (ny_s < 10'sd0) begin
      vy_s  = 7'(-ny_s);
      vdy_s = -dy_r;
    end else if (ny_s > Y_MAX) begin
      vy_s  = 7'(Y_MAX2 - ny_s);
      vdy_s = -dy_r;
    end else begin
      vy_s  = 7'(ny_s);
      vdy_s = dy_r;
    end

    hx_s         = 8'(nx_s);
    hdx_s        = dx_r;
    exit_left_s  = 1'b0;
    exit_right_s = 1'b0;
    // A paddle only reflects a ball travelling towards it
    if (hit_left && (dx_r < 3'sd0)) begin
      hx_s  = ball_x + 8'd2;
      hdx_s = 3'sd2;
    end else if (hit_right && (dx_r > 3'sd0)) begin
      hx_s  = ball_x - 8'd2;
      hdx_s = -3'sd2;
    end else if (nx_s < 10'sd0) begin
      exit_left_s = 1'b1;
    end else if (nx_s > X_MAX) begin
      exit_right_s = 1'b1;
    end else begin
      hx_s = 8'(nx_s);
    end
  end

  // Serve/play state machine with registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      ball_x      <= 8'(X0);
      ball_y      <= 7'(Y0);
      dx_r        <= 3'sd0;
      dy_r        <= 3'sd0;
      cnt_r       <= CNT_W'(0);
      ball_active <= 1'b0;
      serve_busy  <= 1'b0;
      score_left  <= 1'b0;
      score_right <= 1'b0;
    end else begin
      score_left  <= 1'b0;
      score_right <= 1'b0;
      case (state_r)
        IDLE: begin
          ball_x <= 8'(X0);
          ball_y <= 7'(Y0);
          if (serve_req) begin
            state_r    <= WAIT_DIR;
            serve_busy <= 1'b1;
          end
        end
        WAIT_DIR: begin
          if (dir_valid) begin
            dx_r    <= dir_dx_s;
            dy_r    <= dir_dy_s;
            cnt_r   <= CNT_W'(SERVE_DELAY);
            state_r <= DELAY;
          end
        end
        DELAY: begin
          if (frame_tick) begin
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
              state_r     <= PLAY;
              ball_active <= 1'b1;
              serve_busy  <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (frame_tick) begin
            if (exit_left_s) begin
              score_right <= 1'b1;
              ball_active <= 1'b0;
              state_r     <= SCORED;
            end else if (exit_right_s) begin
              score_left  <= 1'b1;
              ball_active <= 1'b0;
              state_r     <= SCORED;
            end else begin
              ball_x <= hx_s;
              dx_r   <= hdx_s;
              ball_y <= vy_s;
              dy_r   <= vdy_s;
            end
          end
        end
        SCORED: begin
          ball_x  <= 8'(X0);
          ball_y  <= 7'(Y0);
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          ball_active <= 1'b0;
          serve_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ball_serve_ctrl.md
# ball_serve_ctrl

Ball serve and motion controller for the Pong datapath. It sits directly downstream of the 3-bit direction LFSR and consumes its done pulse and direction code. On a serve request it latches a direction, waits a fixed number of frames, then moves the ball once per frame. It bounces the ball off the top and bottom walls, reflects it on paddle hits, and pulses a score event when the ball leaves through the left or right edge.

## Interface
- SCREEN_W, 160, playfield width in pixels; the legal x range is 0..SCREEN_W-1.
- SCREEN_H, 120, playfield height in pixels; the legal y range is 0..SCREEN_H-1.
- X0, 80, serve/centre x position.
- Y0, 60, serve/centre y position.
- SERVE_DELAY, 60, frames between direction capture and launch; must be ≥1.
- clock  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- serve_req  input  1  one-cycle serve request; honoured only in IDLE.
- frame_tick  input  1  one-cycle pulse, once per video frame.
- dir_valid  input  1  direction-ready pulse from the direction LFSR.
- dir_code  input  3  direction code from the direction LFSR.
- hit_left  input  1  left paddle overlaps the ball; level signal, sampled on frame_tick.
- hit_right  input  1  right paddle overlaps the ball; level signal, sampled on frame_tick.
- ball_x  output  8  registered ball x position.
- ball_y  output  7  registered ball y position.
- ball_active  output  1  high only in PLAY.
- serve_busy  output  1  high in WAIT_DIR and DELAY.
- score_left  output  1  one-cycle pulse: the ball exited the right edge, so the left player scores.
- score_right  output  1  one-cycle pulse: the ball exited the left edge, so the right player scores.

## Operation
- Reset values:
  - ball_x=X0, ball_y=Y0.
  - ball_active=0, serve_busy=0, score pulses 0.
  - dx=0, dy=0, delay counter 0, state IDLE.
- Direction decode, latched from dir_code:
  - dx = +2 if bit2=1, -2 if bit2=0.
  - dy from bits[1:0]: 00→-2, 01→-1, 10→+1, 11→+2.
  - dy is never 0. Code 000 is legal and decodes to dx=-2, dy=-2.
- FSM:
  - IDLE: ball held at (X0,Y0). serve_req → WAIT_DIR. dir_valid is ignored in IDLE, including when it coincides with serve_req.
  - WAIT_DIR: on dir_valid, latch dx/dy, load counter=SERVE_DELAY → DELAY.
  - DELAY: each frame_tick decrements the counter. A tick with counter==1 → PLAY.
  - PLAY: each frame_tick computes nx=x+dx and ny=y+dy, signed, 10-bit internal.
  - SCORED: lasts exactly 1 cycle. Ball reset to (X0,Y0), then → IDLE.
- PLAY, vertical:
  - ny<0: y=-ny, dy negated.
  - ny>SCREEN_H-1: y=2*(SCREEN_H-1)-ny, dy negated.
  - Otherwise y=ny.
- PLAY, horizontal, evaluated in this priority:
  1. hit_left=1 with dx<0: dx=+2, x=x+2.
  2. hit_right=1 with dx>0: dx=-2, x=x-2.
  3. nx<0: score_right pulse, → SCORED.
  4. nx>SCREEN_W-1: score_left pulse, → SCORED.
  5. Otherwise x=nx.
- A paddle hit against the direction of travel is ignored.
- The vertical update applies on the same tick as a paddle reflection. On a scoring tick the ball position is not updated.
- serve_req outside IDLE is ignored.
- frame_tick has no effect in IDLE or WAIT_DIR.

## Timing
- All outputs are registered. Every change is visible on the cycle after the causing input edge.
- serve_req→serve_busy: 1 cycle.
- dir_valid→DELAY entry: 1 cycle.
- Launch: ball_active rises 1 cycle after the SERVE_DELAY-th frame_tick following direction capture.
- The first position update happens on the next frame_tick after launch.
- Score pulse: high for exactly 1 cycle, coincident with SCORED. ball_active falls in that same cycle.
- ball_x/ball_y return to centre 1 cycle after the score pulse. serve_req is accepted from the following cycle.
- Asserting resetn low in any state forces the reset values immediately, without waiting for a clock edge. The first state change after release is on the first rising edge with resetn=1.

## Test plan
- Reset: hold resetn=0 mid-PLAY with ball at (100,30) → outputs go to (80,60), active=0, busy=0 without a clock edge. After release, with no serve_req, the block stays in IDLE.
- Serve right-down: serve_req, then dir_valid with code 110 → busy=1. After 60 frame_ticks, active=1. Next tick → ball (82,61); next tick → (84,62).
- Top bounce: code 000 and ball at y=1 in PLAY → tick gives y=1, dy=+2. The following tick gives y=3.
- Left paddle: dx=-2, x=1, hit_left=1 on tick → x=3, dx=+2. The same case with hit_left=0 → score_right for 1 cycle, then ball at (80,60) and active=0.
- Right exit: dx=+2, x=158, hit_right=0 → score_left pulse. A serve_req during the SCORED cycle is ignored; a serve_req one cycle later is accepted.
- Ignored events: dir_valid in IDLE, serve_req in DELAY, and hit_right while dx<0 → none changes the state or the ball motion.
